sorted_weight_mac: RTL and testbench

//  Processing-element MAC for the iEEG transformer datapath. Computes one signed dot product of 4-bit weights and 8-bit activations per batch.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_run_mult.sv | 13 +
 rtl/sorted_weight_mac.sv | 100 ++++++++++
 tb/tb_sorted_weight_mac.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths and types for the sorted-weight MAC datapath.
// Result widths cover MAX_LEN beats of worst-case weight x activation.
package mac_pkg;
    localparam int W_WIDTH    = 4;
    localparam int A_WIDTH    = 8;
    localparam int MAX_LEN    = 64;
    localparam int SUM_WIDTH  = A_WIDTH + $clog2(MAX_LEN);
    localparam int OUT_WIDTH  = 18;
    localparam int TRAD_WIDTH = 21;

    typedef logic signed [W_WIDTH-1:0]    weight_t;
    typedef logic signed [A_WIDTH-1:0]    act_t;
    typedef logic signed [SUM_WIDTH-1:0]  run_sum_t;
    typedef logic signed [OUT_WIDTH-1:0]  result_t;
    typedef logic signed [TRAD_WIDTH-1:0] trad_t;
endpackage

// File: rtl/mac_run_mult.sv
// Signed weight x run-sum multiply, sign-extended to the result width.
// Latency: combinational.
// Backpressure: none, pure function of its operands.
module mac_run_mult
    import mac_pkg::*;
(
    input  weight_t  w,
    input  run_sum_t s,
    output result_t  p
);
    // 4x14 signed product needs exactly 18 bits, so no truncation occurs.
    assign p = result_t'(w) * result_t'(s);
endmodule

// File: rtl/sorted_weight_mac.sv
// Dot product of sorted weights and activations; one multiply per equal-weight run.
// Latency: result and output_valid one cycle after acc.  Optional TRAD_MAC_EN adds a per-beat reference sum.
// Backpressure: none; every enabled valid beat is consumed, beats/acc with en=0 are dropped.
module sorted_weight_mac
    import mac_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    reset,
    input  logic    data_valid,
    input  weight_t weight,
    input  act_t    activation,
    input  logic    acc,
    output logic    output_valid,
`ifdef TRAD_MAC_EN
    output trad_t   output_result_trad,
`endif
    output result_t output_result
);
    weight_t  cur_w, cur_w_n;
    run_sum_t run_sum, run_sum_n;
    logic     run_active, run_active_n;
    result_t  part, part_n;
    result_t  close_prod, flush_prod, flush_val;

    mac_run_mult u_close (.w(cur_w),   .s(run_sum),   .p(close_prod));
    mac_run_mult u_flush (.w(cur_w_n), .s(run_sum_n), .p(flush_prod));

    // Absorb this cycle's beat first so a same-cycle acc sees it.
    always_comb begin
        cur_w_n      = cur_w;
        run_sum_n    = run_sum;
        run_active_n = run_active;
        part_n       = part;
        if (data_valid) begin
            if (run_active && (weight == cur_w)) begin
                run_sum_n = run_sum + run_sum_t'(activation);
            end else begin
                if (run_active) begin
                    part_n = part + close_prod;
                end
                cur_w_n      = weight;
                run_sum_n    = run_sum_t'(activation);
                run_active_n = 1'b1;
            end
        end
        flush_val = run_active_n ? (part_n + flush_prod) : part_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_w         <= '0;
            run_sum       <= '0;
            run_active    <= 1'b0;
            part          <= '0;
            output_valid  <= 1'b0;
            output_result <= '0;
        end else if (en) begin
            if (reset) begin
                cur_w         <= '0;
                run_sum       <= '0;
                run_active    <= 1'b0;
                part          <= '0;
                output_valid  <= 1'b0;
                output_result <= '0;
            end else begin
                output_valid <= acc;
                cur_w        <= cur_w_n;
                if (acc) begin
                    output_result <= flush_val;
                    part          <= '0;
                    run_sum       <= '0;
                    run_active    <= 1'b0;
                end else begin
                    part       <= part_n;
                    run_sum    <= run_sum_n;
                    run_active <= run_active_n;
                end
            end
        end
    end

`ifdef TRAD_MAC_EN
    trad_t trad_prod;
    assign trad_prod = trad_t'(weight) * trad_t'(activation);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_result_trad <= '0;
        end else if (en) begin
            if (reset) begin
                output_result_trad <= '0;
            end else if (data_valid) begin
                output_result_trad <= output_result_trad + trad_prod;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sorted_weight_mac.sv
// Self-checking bench for sorted_weight_mac: table of batches plus hand sequences,
// expected batch results queued at acc time and compared when output_valid strobes.
module tb_sorted_weight_mac;
    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               reset;
    logic               data_valid;
    logic signed [3:0]  weight;
    logic signed [7:0]  activation;
    logic               acc;
    logic               output_valid;
    logic signed [17:0] output_result;
`ifdef TRAD_MAC_EN
    logic signed [20:0] output_result_trad;
`endif

    sorted_weight_mac dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .reset              (reset),
        .data_valid         (data_valid),
        .weight             (weight),
        .activation         (activation),
        .acc                (acc),
        .output_valid       (output_valid),
`ifdef TRAD_MAC_EN
        .output_result_trad (output_result_trad),
`endif
        .output_result      (output_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [3:0]  w;
        logic signed [7:0]  a;
        logic               last;
        logic signed [17:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped;
    int   sw_sum;
    int   rw;
    int   ra;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input int w, input int a, input int last, input int e);
        vec_t v;
        v.w    = 4'(w);
        v.a    = 8'(a);
        v.last = (last != 0);
        v.exp  = 18'(e);
        return v;
    endfunction

    // One cycle of stimulus; an acc queues the expected batch result.
    task automatic drive(input int dv, input int w, input int a, input int ac, input int e);
        data_valid = (dv != 0);
        weight     = 4'(w);
        activation = 8'(a);
        acc        = (ac != 0);
        if (ac != 0) exp_q.push_back(e);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        acc        = 1'b0;
    endtask

    always @(negedge clk) begin
        if (output_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got strobe with result %0d, expected no strobe", output_result);
            end else begin
                popped = exp_q.pop_front();
                check("batch_result", int'(output_result), popped);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; reset = 1'b0;
        data_valid = 1'b0; acc = 1'b0; weight = '0; activation = '0;
        #2;
        check("rst_valid", int'(output_valid), 0);
        check("rst_result", int'(output_result), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Worst-case magnitude batch, then latency and one-cycle strobe.
        for (int i = 0; i < 64; i++) drive(1, -8, -128, 0, 0);
        drive(0, 0, 0, 1, 65536);
        check("valid_latency", int'(output_valid), 1);
        @(posedge clk); #1;
        check("valid_one_cycle", int'(output_valid), 0);
        check("result_hold", int'(output_result), 65536);
`ifdef TRAD_MAC_EN
        check("trad_extreme", int'(output_result_trad), 65536);
`endif

        drive(1, 1, 10, 0, 0);
        drive(1, 1, 20, 0, 0);
        drive(1, 2, 30, 0, 0);
        drive(0, 0, 0, 1, 90);

        // Table batches: acc rides on the final beat of each batch.
        tbl.push_back(mk( 3,    5, 0,     0));
        tbl.push_back(mk(-3,    5, 0,     0));
        tbl.push_back(mk( 3,    5, 0,     0));
        tbl.push_back(mk(-3,    5, 1,     0));
        tbl.push_back(mk( 7,  127, 1,   889));
        tbl.push_back(mk(-1,   -1, 0,     0));
        tbl.push_back(mk(-1,   -1, 0,     0));
        tbl.push_back(mk( 5, -128, 1,  -638));
        tbl.push_back(mk(-8,  127, 0,     0));
        tbl.push_back(mk(-8,  127, 0,     0));
        tbl.push_back(mk( 7, -128, 1, -2928));
        tbl.push_back(mk( 2,   -4, 0,     0));
        tbl.push_back(mk( 0,  100, 0,     0));
        tbl.push_back(mk( 2,    3, 1,    -2));
        tbl.push_back(mk(-8, -128, 1,  1024));
        for (int i = 0; i < tbl.size(); i++)
            drive(1, int'(tbl[i].w), int'(tbl[i].a), int'(tbl[i].last), int'(tbl[i].exp));

        // Empty batch, then acc coinciding with the last beat.
        drive(0, 0, 0, 1, 0);
        drive(1, 1, 10, 0, 0);
        drive(1, 2, -4, 1, 2);

        // Synchronous clear beats a same-cycle beat and acc; no strobe.
        drive(1, 1, 10, 0, 0);
        drive(1, 1, 20, 0, 0);
        reset = 1'b1; data_valid = 1'b1; weight = 4'sd3; activation = 8'sd9; acc = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; data_valid = 1'b0; acc = 1'b0;
        check("reset_result", int'(output_result), 0);
        check("reset_valid", int'(output_valid), 0);
        drive(1, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 1);

        // Beats and acc while disabled are dropped.
        drive(1, 1, 10, 0, 0);
        en = 1'b0;
        data_valid = 1'b1; weight = 4'sd5; activation = 8'sd50;
        repeat (2) begin @(posedge clk); #1; end
        acc = 1'b1;
        @(posedge clk); #1;
        check("en_hold_result", int'(output_result), 1);
        check("en_hold_valid", int'(output_valid), 0);
        en = 1'b1; data_valid = 1'b0; acc = 1'b0;
        drive(1, 1, 20, 0, 0);
        drive(0, 0, 0, 1, 30);

        // Asynchronous reset between edges mid-batch.
        drive(1, 3, 3, 0, 0);
        drive(1, 3, 3, 0, 0);
        #3 rst = 1'b1;
        #1;
        check("arst_result", int'(output_result), 0);
        check("arst_valid", int'(output_valid), 0);
`ifdef TRAD_MAC_EN
        check("arst_trad", int'(output_result_trad), 0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        // Random 64-beat batch against the software dot product.
        sw_sum = 0;
        for (int i = 0; i < 64; i++) begin
            rw = int'($urandom_range(0, 15)) - 8;
            ra = int'($urandom_range(0, 255)) - 128;
            sw_sum += rw * ra;
            drive(1, rw, ra, 0, 0);
        end
        drive(0, 0, 0, 1, sw_sum);

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule
